// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle sensor conditioner.
// Optional build macro used by the top level: OBSTACLE_EVENT_COUNT_EN.
package obstacle_pkg;

   typedef enum logic [1:0] {
      CLEAR     = 2'd0,
      NEAR_PEND = 2'd1,
      BLOCKED   = 2'd2,
      FAR_PEND  = 2'd3
   } chan_state_t;

   localparam int FAULT_TIMEOUT = 0;
   localparam int FAULT_BADCH   = 1;
   localparam int FAULT_W       = 2;

   localparam int DEF_NUM_CH   = 3;
   localparam int DEF_DIST_W   = 8;
   localparam int DEF_NEAR_TH  = 40;
   localparam int DEF_FAR_TH   = 48;
   localparam int DEF_DEBOUNCE = 4;
   localparam int DEF_TIMEOUT  = 1000;

   localparam int EVT_W = 16;

   // A channel reports an obstacle until its far debounce completes.
   function automatic logic is_obstructed(input chan_state_t s);
      return (s == BLOCKED) || (s == FAR_PEND);
   endfunction

endpackage

// File: rtl/obstacle_channel_fsm.sv
// One sensor channel: hysteresis/debounce FSM plus sample watchdog.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   CLEAR     | path free, no near samples pending
//   NEAR_PEND | counting consecutive near samples toward BLOCKED
//   BLOCKED   | obstacle reported, no far samples pending
//   FAR_PEND  | obstacle reported, counting far samples toward CLEAR
module obstacle_channel_fsm
   import obstacle_pkg::*;
#(
   parameter int DIST_W   = DEF_DIST_W,
   parameter int NEAR_TH  = DEF_NEAR_TH,
   parameter int FAR_TH   = DEF_FAR_TH,
   parameter int DEBOUNCE = DEF_DEBOUNCE,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              err_i,
   input  logic              sample_i,
   input  logic [DIST_W-1:0] dist_i,
   output logic              blocked_o,
   output logic              timeout_o,
   output logic              entry_o
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

   chan_state_t      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             blocked_q;
   logic             entry_q;
   logic [TMR_W-1:0] timer_q;
   logic [TMR_W-1:0] timer_d;

   logic             near_w;
   logic             far_w;
   logic [CNT_W-1:0] cnt_inc_w;
   logic             cnt_hit_w;

   // Band samples (NEAR_TH <= d < FAR_TH) are neither near nor far.
   assign near_w    = dist_i <  DIST_W'(NEAR_TH);
   assign far_w     = dist_i >= DIST_W'(FAR_TH);
   // Count is 0 in CLEAR/BLOCKED, so the increment also covers the first sample.
   assign cnt_inc_w = cnt_q + 1'b1;
   assign cnt_hit_w = (cnt_inc_w == CNT_DONE);

   // Debounce FSM; moves only on an accepted sample or an error clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         blocked_q <= 1'b0;
         entry_q   <= 1'b0;
      end else begin
         entry_q <= 1'b0;
         if (clr_i) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            blocked_q <= 1'b0;
         end else if (sample_i) begin
            unique case (state_q)
               CLEAR, NEAR_PEND: begin
                  if (!near_w) begin
                     state_q <= CLEAR;
                     cnt_q   <= '0;
                  end else if (cnt_hit_w) begin
                     state_q   <= BLOCKED;
                     cnt_q     <= '0;
                     blocked_q <= 1'b1;
                     entry_q   <= 1'b1;
                  end else begin
                     state_q <= NEAR_PEND;
                     cnt_q   <= cnt_inc_w;
                  end
               end
               BLOCKED, FAR_PEND: begin
                  if (!far_w) begin
                     state_q <= BLOCKED;
                     cnt_q   <= '0;
                  end else if (cnt_hit_w) begin
                     state_q   <= CLEAR;
                     cnt_q     <= '0;
                     blocked_q <= 1'b0;
                  end else begin
                     state_q <= FAR_PEND;
                     cnt_q   <= cnt_inc_w;
                  end
               end
            endcase
         end
      end
   end

   // Watchdog next value: restart on sample/clear, count up while healthy, saturate.
   always_comb begin
      timer_d = timer_q;
      if (clr_i || sample_i) begin
         timer_d = '0;
      end else if (!err_i && (timer_q != TMR_MAX)) begin
         timer_d = timer_q + 1'b1;
      end
   end

   // Watchdog register.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   // Fires only on the step out of TIMEOUT-1, so a frozen timer never re-fires.
   assign timeout_o = !err_i && !sample_i && (timer_q == TMR_LAST);
   assign blocked_o = blocked_q;
   assign entry_o   = entry_q;

endmodule

// File: rtl/obstacle_sensor_conditioner.sv
// Obstacle sensor conditioner: sample handshake, channel decode, error latch
// and fail-safe forcing of the obstacle vector.
// Optional build macro: OBSTACLE_EVENT_COUNT_EN adds per-channel BLOCKED-entry
// counters on obstacle_events.
module obstacle_sensor_conditioner
   import obstacle_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int DIST_W   = DEF_DIST_W,
   parameter int NEAR_TH  = DEF_NEAR_TH,
   parameter int FAR_TH   = DEF_FAR_TH,
   parameter int DEBOUNCE = DEF_DEBOUNCE,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [1:0]         s_ch,
   input  logic [DIST_W-1:0]  s_dist,
   input  logic               err_clear,
   output logic [NUM_CH-1:0]  obstacle,
   output logic               error_detected,
   output logic [FAULT_W-1:0] fault_code
`ifdef OBSTACLE_EVENT_COUNT_EN
   ,
   output logic [NUM_CH*EVT_W-1:0] obstacle_events
`endif
);

   logic               accept_w;
   logic               bad_ch_w;
   logic               clr_w;
   logic [NUM_CH-1:0]  sample_w;
   logic [NUM_CH-1:0]  blocked_w;
   logic [NUM_CH-1:0]  timeout_w;
   logic [NUM_CH-1:0]  entry_w;
   logic [FAULT_W-1:0] new_fault_w;

   logic               error_q;
   logic               error_d;
   logic [FAULT_W-1:0] fault_q;
   logic [FAULT_W-1:0] fault_d;

   // Upstream stalls while reset is applied or a fault is latched.
   assign s_ready  = !reset && !error_q;
   assign accept_w = s_valid && s_ready;
   assign bad_ch_w = accept_w && ({1'b0, s_ch} >= 3'(NUM_CH));
   assign clr_w    = error_q && err_clear;

   // Route an accepted, in-range sample to its channel.
   always_comb begin
      sample_w = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sample_w[i] = accept_w && !bad_ch_w && (s_ch == 2'(i));
      end
   end

   // Collect this cycle's new faults and form the next error/fault state.
   always_comb begin
      new_fault_w                = '0;
      new_fault_w[FAULT_TIMEOUT] = |timeout_w;
      new_fault_w[FAULT_BADCH]   = bad_ch_w;
      // A fault arriving with err_clear keeps the error raised.
      error_d = (error_q && !err_clear) || (|new_fault_w);
      fault_d = (clr_w ? '0 : fault_q) | new_fault_w;
   end

   // Error latch and sticky fault code.
   always_ff @(posedge clk) begin
      if (reset) begin
         error_q <= 1'b0;
         fault_q <= '0;
      end else begin
         error_q <= error_d;
         fault_q <= fault_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      obstacle_channel_fsm #(
         .DIST_W   (DIST_W),
         .NEAR_TH  (NEAR_TH),
         .FAR_TH   (FAR_TH),
         .DEBOUNCE (DEBOUNCE),
         .TIMEOUT  (TIMEOUT)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .clr_i     (clr_w),
         .err_i     (error_q),
         .sample_i  (sample_w[g]),
         .dist_i    (s_dist),
         .blocked_o (blocked_w[g]),
         .timeout_o (timeout_w[g]),
         .entry_o   (entry_w[g])
      );
   end

   // Fail-safe: report every channel blocked while a fault is latched.
   assign obstacle       = error_q ? {NUM_CH{1'b1}} : blocked_w;
   assign error_detected = error_q;
   assign fault_code     = fault_q;

`ifdef OBSTACLE_EVENT_COUNT_EN
   logic [EVT_W-1:0] evt_q [NUM_CH];

   // Saturating BLOCKED-entry counters; survive err_clear, cleared by reset only.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset) begin
            evt_q[i] <= '0;
         end else if (entry_w[i] && (evt_q[i] != {EVT_W{1'b1}})) begin
            evt_q[i] <= evt_q[i] + 1'b1;
         end
      end
   end

   // Pack the counters, channel 0 in the low lane.
   always_comb begin
      obstacle_events = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         obstacle_events[i*EVT_W +: EVT_W] = evt_q[i];
      end
   end
`else
   logic unused_entry_w;
   assign unused_entry_w = ^entry_w;
`endif

endmodule

// File: tb/tb_obstacle_sensor_conditioner.sv
// Bench for obstacle_sensor_conditioner: directed vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_obstacle_sensor_conditioner;

   localparam int NUM_CH   = 3;
   localparam int DIST_W   = 8;
   localparam int NEAR_TH  = 40;
   localparam int FAR_TH   = 48;
   localparam int DEBOUNCE = 4;
   localparam int TIMEOUT  = 1000;

   logic              clk;
   logic              reset;
   logic              s_valid;
   logic              s_ready;
   logic [1:0]        s_ch;
   logic [DIST_W-1:0] s_dist;
   logic              err_clear;
   logic [NUM_CH-1:0] obstacle;
   logic              error_detected;
   logic [1:0]        fault_code;

   int total = 0;
   int bad   = 0;

   // Behavioural model: per channel a blocked flag, the run length of
   // consecutive samples qualifying to flip it, and the age since last sample.
   bit       m_blk [NUM_CH];
   int       m_run [NUM_CH];
   int       m_age [NUM_CH];
   bit       m_err;
   bit [1:0] m_fault;

   obstacle_sensor_conditioner #(
      .NUM_CH(NUM_CH), .DIST_W(DIST_W), .NEAR_TH(NEAR_TH),
      .FAR_TH(FAR_TH), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_ch           (s_ch),
      .s_dist         (s_dist),
      .err_clear      (err_clear),
      .obstacle       (obstacle),
      .error_detected (error_detected),
      .fault_code     (fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit rst, input bit v, input int ch, input int d, input bit clr);
      bit [1:0] nf;
      bit       clr_act;
      bit       smp [NUM_CH];
      bit       qual;
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_blk[i] = 0; m_run[i] = 0; m_age[i] = 0;
         end
         m_err = 0; m_fault = 0;
         return;
      end
      nf = 0;
      clr_act = m_err && clr;
      for (int i = 0; i < NUM_CH; i++) smp[i] = 0;
      if (v && !m_err) begin
         if (ch >= NUM_CH) nf[1] = 1;
         else smp[ch] = 1;
      end
      for (int i = 0; i < NUM_CH; i++)
         if (!m_err && !smp[i] && m_age[i] == TIMEOUT - 1) nf[0] = 1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (clr_act) begin
            m_blk[i] = 0; m_run[i] = 0; m_age[i] = 0;
         end else if (smp[i]) begin
            m_age[i] = 0;
            qual = m_blk[i] ? (d >= FAR_TH) : (d < NEAR_TH);
            if (qual) begin
               m_run[i]++;
               if (m_run[i] == DEBOUNCE) begin
                  m_blk[i] = !m_blk[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end else if (!m_err && m_age[i] < TIMEOUT) begin
            m_age[i]++;
         end
      end
      m_fault = (clr_act ? 2'b00 : m_fault) | nf;
      m_err   = (m_err && !clr) || (nf != 0);
   endtask

   // Apply one cycle of inputs, advance the model, compare all outputs.
   task automatic cyc(input bit rst, input bit v, input int ch, input int d, input bit clr);
      int exp_obst;
      reset     = rst;
      s_valid   = v;
      s_ch      = 2'(ch);
      s_dist    = DIST_W'(d);
      err_clear = clr;
      @(posedge clk);
      model_edge(rst, v, ch, d, clr);
      #1;
      exp_obst = 0;
      for (int i = 0; i < NUM_CH; i++) if (m_blk[i]) exp_obst |= (1 << i);
      if (m_err) exp_obst = (1 << NUM_CH) - 1;
      chk("model_obstacle", int'(obstacle), exp_obst);
      chk("model_error", int'(error_detected), int'(m_err));
      chk("model_fault", int'(fault_code), int'(m_fault));
      chk("model_ready", int'(s_ready), int'(!rst && !m_err));
   endtask

   typedef struct {
      bit       rst;
      bit       v;
      int       ch;
      int       d;
      bit       clr;
      bit [2:0] eo;
      bit       ee;
      bit [1:0] ef;
      bit       er;
   } vec_t;

   vec_t tbl [15];
   int   seq2 [7];
   int   exp2 [7];

   initial begin
      int k_hit;
      int ch;
      int d;
      bit starve;

      // rst v ch d clr | obstacle err fault ready
      tbl[0]  = '{1, 0, 0,   0, 0, 3'b000, 0, 2'b00, 0};
      tbl[1]  = '{0, 1, 0,  20, 0, 3'b000, 0, 2'b00, 1};
      tbl[2]  = '{0, 1, 0,  20, 0, 3'b000, 0, 2'b00, 1};
      tbl[3]  = '{0, 1, 0,  20, 0, 3'b000, 0, 2'b00, 1};
      tbl[4]  = '{0, 1, 0,  20, 0, 3'b001, 0, 2'b00, 1};
      tbl[5]  = '{0, 1, 1,  30, 0, 3'b001, 0, 2'b00, 1};
      tbl[6]  = '{0, 1, 1,  39, 0, 3'b001, 0, 2'b00, 1};
      tbl[7]  = '{0, 1, 1,   0, 0, 3'b001, 0, 2'b00, 1};
      tbl[8]  = '{0, 1, 1,  30, 0, 3'b011, 0, 2'b00, 1};
      tbl[9]  = '{0, 1, 0,  60, 0, 3'b011, 0, 2'b00, 1};
      tbl[10] = '{0, 1, 2,  40, 0, 3'b011, 0, 2'b00, 1};
      tbl[11] = '{0, 1, 3,  10, 0, 3'b111, 1, 2'b10, 0};
      tbl[12] = '{0, 1, 0,  20, 0, 3'b111, 1, 2'b10, 0};
      tbl[13] = '{0, 0, 0,   0, 1, 3'b000, 0, 2'b00, 1};
      tbl[14] = '{0, 1, 0,  20, 0, 3'b000, 0, 2'b00, 1};

      seq2 = '{50, 50, 44, 50, 50, 50, 50};
      exp2 = '{1, 1, 1, 1, 1, 1, 0};

      // Directed vector table: debounce, band sample, bad channel, stall, clear.
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].rst, tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].clr);
         chk($sformatf("tbl%0d_obstacle", i), int'(obstacle), int'(tbl[i].eo));
         chk($sformatf("tbl%0d_error", i), int'(error_detected), int'(tbl[i].ee));
         chk($sformatf("tbl%0d_fault", i), int'(fault_code), int'(tbl[i].ef));
         chk($sformatf("tbl%0d_ready", i), int'(s_ready), int'(tbl[i].er));
      end

      // Far debounce on ch1 restarted by a band sample.
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, 20, 0);
      chk("seq2_blocked", int'(obstacle), 2);
      for (int i = 0; i < 7; i++) begin
         cyc(0, 1, 1, seq2[i], 0);
         chk($sformatf("seq2_step%0d", i), int'(obstacle[1]), exp2[i]);
      end

      // Starve ch2 while ch0/ch1 are fed: timeout after exactly TIMEOUT cycles.
      cyc(1, 0, 0, 0, 0);
      k_hit = -1;
      for (int k = 1; k <= TIMEOUT + 100; k++) begin
         cyc(0, 1, k % 2, 100, 0);
         if (error_detected) begin
            k_hit = k;
            break;
         end
      end
      chk("timeout_cycle", k_hit, TIMEOUT);
      chk("timeout_fault", int'(fault_code), 1);
      chk("timeout_obstacle", int'(obstacle), 7);
      chk("timeout_ready", int'(s_ready), 0);

      // Timer at TIMEOUT-1 with err_clear in the firing cycle: fault wins.
      cyc(1, 0, 0, 0, 0);
      for (int k = 1; k < TIMEOUT; k++) cyc(0, 0, 0, 0, 0);
      chk("pre_timeout_error", int'(error_detected), 0);
      cyc(0, 0, 0, 0, 1);
      chk("clr_vs_timeout_error", int'(error_detected), 1);
      chk("clr_vs_timeout_fault0", int'(fault_code[0]), 1);
      cyc(0, 0, 0, 0, 1);
      chk("clear_error", int'(error_detected), 0);
      chk("clear_obstacle", int'(obstacle), 0);
      cyc(0, 0, 0, 0, 0);
      chk("no_refire", int'(error_detected), 0);

      // Reset mid-debounce discards the pending count.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 20, 0);
      cyc(0, 1, 0, 20, 0);
      cyc(1, 1, 0, 20, 0);
      chk("rst_obstacle", int'(obstacle), 0);
      chk("rst_error", int'(error_detected), 0);
      chk("rst_fault", int'(fault_code), 0);
      chk("rst_ready", int'(s_ready), 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 20, 0);
      chk("rst_3near", int'(obstacle), 0);
      cyc(0, 1, 0, 20, 0);
      chk("rst_4near", int'(obstacle), 1);

      // Randomized run; ch2 is starved for a stretch to provoke timeouts.
      cyc(1, 0, 0, 0, 0);
      for (int n = 0; n < 2500; n++) begin
         starve = (n >= 500) && (n < 1800);
         if (starve) ch = int'($urandom_range(0, 1));
         else if ($urandom_range(0, 63) == 0) ch = 3;
         else ch = int'($urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0) d = int'($urandom_range(0, 255));
         else d = int'($urandom_range(34, 54));
         cyc($urandom_range(0, 699) == 0, $urandom_range(0, 3) != 0, ch, d,
             $urandom_range(0, 19) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
